mux_univ_reg: RTL

- Parametrised universal register. Every bit is a 2:1-mux-feedback storage cell generalised to a WIDTH-bit register with an op-decoded next-state mux.
- Supports hold, parallel load, single-step shift and rotate, clear, and a multi-cycle N-step shift/rotate sequence with busy/done handshake.
- Successor to the single-bit mux storage element. Used as a data-path register and serialiser in later designs.

---
 rtl/mux_univ_reg.sv | 118 +++++++++++
 1 files changed

// File: rtl/mux_univ_reg.sv
// Universal WIDTH-bit register: hold/load/shift/rotate/clear plus a counted
// multi-step shift/rotate sequence with busy/done handshake.
module mux_univ_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    input  logic             dir,
    input  logic             rot,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             msb_out,
    output logic             lsb_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [2:0] OpHold  = 3'b000;
    localparam logic [2:0] OpLoad  = 3'b001;
    localparam logic [2:0] OpShl   = 3'b010;
    localparam logic [2:0] OpShr   = 3'b011;
    localparam logic [2:0] OpRol   = 3'b100;
    localparam logic [2:0] OpRor   = 3'b101;
    localparam logic [2:0] OpClr   = 3'b110;
    localparam logic [2:0] OpStart = 3'b111;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             dir_l;
    logic             rot_l;

    logic             step_fill;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] single_q;

    // One multi-step move using the latched direction/mode; ser_in sampled live.
    always_comb begin
        step_fill = ser_in;
        step_q    = q;
        if (!dir_l) begin
            step_fill = rot_l ? q[WIDTH-1] : ser_in;
            step_q    = {q[WIDTH-2:0], step_fill};
        end else begin
            step_fill = rot_l ? q[0] : ser_in;
            step_q    = {step_fill, q[WIDTH-1:1]};
        end
    end

    always_comb begin
        single_q = q;
        case (op)
            OpHold:  single_q = q;
            OpLoad:  single_q = d;
            OpShl:   single_q = {q[WIDTH-2:0], ser_in};
            OpShr:   single_q = {ser_in, q[WIDTH-1:1]};
            OpRol:   single_q = {q[WIDTH-2:0], q[WIDTH-1]};
            OpRor:   single_q = {q[0], q[WIDTH-1:1]};
            OpClr:   single_q = '0;
            OpStart: single_q = q;
            default: single_q = q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= StIdle;
            q     <= '0;
            cnt   <= '0;
            dir_l <= 1'b0;
            rot_l <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (en) begin
                        q <= single_q;
                        if (op == OpStart) begin
                            dir_l <= dir;
                            rot_l <= rot;
                            if (count == '0) begin
                                done <= 1'b1;
                            end else begin
                                cnt   <= count;
                                busy  <= 1'b1;
                                state <= StRun;
                            end
                        end
                    end
                end
                StRun: begin
                    q <= step_q;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                    if (cnt <= CNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign msb_out = q[WIDTH-1];
    assign lsb_out = q[0];

endmodule
